// File: rtl/fir_tdm_if.sv
// Sample-input and result-output handshake bundle for the time-shared FIR scheduler.
// The slave modport is the scheduler's view; the master modport is the traffic source/sink.
interface fir_tdm_if #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 8,
   parameter int OUT_W  = 20
);
   logic [NUM_CH*DATA_W-1:0] ch_data;
   logic [NUM_CH-1:0]        ch_valid;
   logic [NUM_CH-1:0]        ch_ready;
   logic signed [OUT_W-1:0]  data_out;
   logic [2:0]               ch_id_out;
   logic                     valid_out;
   logic                     out_ready;

   modport slave (
      input  ch_data, ch_valid, out_ready,
      output ch_ready, data_out, ch_id_out, valid_out
   );

   modport master (
      output ch_data, ch_valid, out_ready,
      input  ch_ready, data_out, ch_id_out, valid_out
   );
endinterface

// File: rtl/fir_tdm_scheduler.sv
// 3-tap FIR sharing one signed multiplier/accumulator among NUM_CH streams.
// Round-robin grant in IDLE, then three tap cycles, then a held result until accepted.
module fir_tdm_scheduler #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 8,
   parameter int OUT_W  = 20
) (
   input  logic                     clk,
   input  logic                     rst_n,
   fir_tdm_if.slave                 bus,
   input  logic                     cfg_we,
   input  logic [1:0]               cfg_addr,
   input  logic signed [DATA_W-1:0] cfg_data,
   output logic                     cfg_busy,
   input  logic                     flush
);
   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int PROD_W = 2 * DATA_W;

   typedef enum logic [2:0] {IDLE, TAP0, TAP1, TAP2, OUT} state_t;

   state_t                   state_q, state_d;
   logic signed [DATA_W-1:0] x0_q, x0_d;
   logic [CH_W-1:0]          cur_ch_q, cur_ch_d;
   logic [CH_W-1:0]          rr_last_q, rr_last_d;
   logic signed [OUT_W-1:0]  acc_q, acc_d;
   logic signed [OUT_W-1:0]  data_out_q, data_out_d;
   logic [2:0]               ch_id_q, ch_id_d;
   logic                     valid_q, valid_d;
   logic signed [DATA_W-1:0] coef_q [3];
   logic signed [DATA_W-1:0] coef_d [3];
   logic signed [DATA_W-1:0] x1_q [NUM_CH];
   logic signed [DATA_W-1:0] x1_d [NUM_CH];
   logic signed [DATA_W-1:0] x2_q [NUM_CH];
   logic signed [DATA_W-1:0] x2_d [NUM_CH];
   logic signed [DATA_W-1:0] sample [NUM_CH];

   logic                     grant_valid;
   logic [CH_W-1:0]          grant_ch;
   logic [CH_W-1:0]          cand;
   logic                     take;
   logic signed [DATA_W-1:0] mul_a, mul_b;
   logic signed [PROD_W-1:0] prod;
   logic signed [OUT_W-1:0]  prod_ext;

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign sample[gi] = bus.ch_data[gi*DATA_W +: DATA_W];
   end

   // Search starts one past the last winner so every requester is served in turn.
   always_comb begin
      grant_valid = 1'b0;
      grant_ch    = '0;
      cand        = '0;
      for (int off = 1; off <= NUM_CH; off++) begin
         cand = CH_W'((int'(rr_last_q) + off) % NUM_CH);
         if (!grant_valid && bus.ch_valid[cand]) begin
            grant_valid = 1'b1;
            grant_ch    = cand;
         end
      end
   end

   assign take         = (state_q == IDLE) && !flush && grant_valid;
   assign bus.ch_ready = take ? (NUM_CH'(1) << grant_ch) : '0;
   assign cfg_busy     = (state_q != IDLE);

   always_comb begin
      mul_a = '0;
      mul_b = '0;
      case (state_q)
         TAP0: begin mul_a = x0_q;           mul_b = coef_q[0]; end
         TAP1: begin mul_a = x1_q[cur_ch_q]; mul_b = coef_q[1]; end
         TAP2: begin mul_a = x2_q[cur_ch_q]; mul_b = coef_q[2]; end
         default: ;
      endcase
   end

   assign prod     = mul_a * mul_b;
   assign prod_ext = {{(OUT_W-PROD_W){prod[PROD_W-1]}}, prod};

   always_comb begin
      state_d    = state_q;
      x0_d       = x0_q;
      cur_ch_d   = cur_ch_q;
      rr_last_d  = rr_last_q;
      acc_d      = acc_q;
      data_out_d = data_out_q;
      ch_id_d    = ch_id_q;
      valid_d    = valid_q;
      coef_d     = coef_q;
      x1_d       = x1_q;
      x2_d       = x2_q;

      if (flush) begin
         state_d = IDLE;
         valid_d = 1'b0;
         for (int k = 0; k < NUM_CH; k++) begin
            x1_d[k] = '0;
            x2_d[k] = '0;
         end
      end else begin
         case (state_q)
            IDLE: if (take) begin
               x0_d      = sample[grant_ch];
               cur_ch_d  = grant_ch;
               rr_last_d = grant_ch;
               state_d   = TAP0;
            end
            TAP0: begin
               acc_d   = prod_ext;
               state_d = TAP1;
            end
            TAP1: begin
               acc_d   = acc_q + prod_ext;
               state_d = TAP2;
            end
            TAP2: begin
               data_out_d     = acc_q + prod_ext;
               ch_id_d        = 3'(cur_ch_q);
               valid_d        = 1'b1;
               x2_d[cur_ch_q] = x1_q[cur_ch_q];
               x1_d[cur_ch_q] = x0_q;
               state_d        = OUT;
            end
            OUT: if (bus.out_ready) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end

      // Taps read coefficients only after IDLE, so a same-edge write applies to that sample.
      if ((state_q == IDLE) && cfg_we && (cfg_addr != 2'd3)) begin
         coef_d[cfg_addr] = cfg_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         x0_q       <= '0;
         cur_ch_q   <= '0;
         rr_last_q  <= CH_W'(NUM_CH - 1);
         acc_q      <= '0;
         data_out_q <= '0;
         ch_id_q    <= '0;
         valid_q    <= 1'b0;
         coef_q[0]  <= DATA_W'(1);
         coef_q[1]  <= DATA_W'(2);
         coef_q[2]  <= DATA_W'(1);
         for (int k = 0; k < NUM_CH; k++) begin
            x1_q[k] <= '0;
            x2_q[k] <= '0;
         end
      end else begin
         state_q    <= state_d;
         x0_q       <= x0_d;
         cur_ch_q   <= cur_ch_d;
         rr_last_q  <= rr_last_d;
         acc_q      <= acc_d;
         data_out_q <= data_out_d;
         ch_id_q    <= ch_id_d;
         valid_q    <= valid_d;
         coef_q     <= coef_d;
         x1_q       <= x1_d;
         x2_q       <= x2_d;
      end
   end

   assign bus.data_out  = data_out_q;
   assign bus.ch_id_out = ch_id_q;
   assign bus.valid_out = valid_q;
endmodule

// File: tb/tb_fir_tdm_scheduler.sv
// Directed bench for fir_tdm_scheduler: impulse, round-robin, stall, coefficient
// writes, flush and mid-operation reset, all against hand-computed results.
module tb_fir_tdm_scheduler;
   localparam int NUM_CH = 4;
   localparam int DATA_W = 8;
   localparam int OUT_W  = 20;

   logic                     clk;
   logic                     rst_n;
   logic                     cfg_we;
   logic [1:0]               cfg_addr;
   logic signed [DATA_W-1:0] cfg_data;
   logic                     cfg_busy;
   logic                     flush;

   int n_cmp = 0;
   int n_err = 0;

   fir_tdm_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .OUT_W(OUT_W)) bus ();

   fir_tdm_scheduler #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .OUT_W(OUT_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .cfg_we   (cfg_we),
      .cfg_addr (cfg_addr),
      .cfg_data (cfg_data),
      .cfg_busy (cfg_busy),
      .flush    (flush)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Present a sample on one channel, wait for its grant and return at the negedge after transfer.
   task automatic start_sample(input int ch, input int val, input string tag);
      int w;
      bus.ch_data[ch*DATA_W +: DATA_W] = DATA_W'(val);
      bus.ch_valid[ch] = 1'b1;
      w = 0;
      #1;
      while (!bus.ch_ready[ch] && w < 50) begin
         @(negedge clk);
         #1;
         w++;
      end
      check({tag, " grant"}, bus.ch_ready[ch], 1);
      @(negedge clk);
      bus.ch_valid[ch] = 1'b0;
   endtask

   // lat0 = negedges already elapsed since the transfer-edge negedge.
   task automatic expect_result(input int ch, input int exp, input string tag, input int lat0);
      int lat;
      lat = lat0;
      while (!bus.valid_out && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check({tag, " lat"}, lat, 3);
      check({tag, " data"}, bus.data_out, exp);
      check({tag, " id"}, bus.ch_id_out, ch);
      $display("result %-10s ch=%0d data=%0d (exp %0d) lat=%0d", tag, bus.ch_id_out, bus.data_out, exp, lat);
      @(negedge clk);
   endtask

   int imp_in  [4] = '{64, 0, 0, 0};
   int imp_exp [4] = '{64, 128, 64, 0};
   int rr_id   [5] = '{0, 1, 2, 3, 0};
   int rr_val  [5] = '{1, 2, 3, 4, 3};

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      logic seen;

      rst_n        = 1'b0;
      bus.ch_data  = '0;
      bus.ch_valid = '0;
      bus.out_ready = 1'b1;
      cfg_we       = 1'b0;
      cfg_addr     = 2'd0;
      cfg_data     = '0;
      flush        = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      check("rst data_out", bus.data_out, 0);
      check("rst valid_out", bus.valid_out, 0);
      check("rst ch_ready", bus.ch_ready, 0);
      check("rst cfg_busy", cfg_busy, 0);
      check("rst ch_id", bus.ch_id_out, 0);

      // Impulse on ch0 reads back default coefficients 1,2,1.
      for (int i = 0; i < 4; i++) begin
         start_sample(0, imp_in[i], $sformatf("imp%0d", i));
         expect_result(0, imp_exp[i], $sformatf("imp%0d", i), 0);
      end

      // A ch3 sample moves the round-robin pointer so ch0 is next.
      start_sample(3, 0, "pre3");
      expect_result(3, 0, "pre3", 0);

      bus.ch_data  = {8'sd4, 8'sd3, 8'sd2, 8'sd1};
      bus.ch_valid = 4'hF;
      for (int i = 0; i < 5; i++) begin
         lat = 0;
         while (!bus.valid_out && lat < 30) begin
            @(negedge clk);
            lat++;
         end
         check($sformatf("rr%0d wait", i), (lat < 30), 1);
         check($sformatf("rr%0d id", i), bus.ch_id_out, rr_id[i]);
         check($sformatf("rr%0d data", i), bus.data_out, rr_val[i]);
         check($sformatf("rr%0d ready_in_out", i), bus.ch_ready, 0);
         $display("result rr%0d ch=%0d data=%0d", i, bus.ch_id_out, bus.data_out);
         if (i == 4) bus.ch_valid = '0;
         @(negedge clk);
      end

      // Flush in IDLE with a requester present: no grant, histories cleared.
      bus.ch_valid = 4'b0100;
      flush = 1'b1;
      #1;
      check("flush ready", bus.ch_ready, 0);
      @(negedge clk);
      bus.ch_valid = '0;
      flush = 1'b0;
      #1;
      check("flush idle", cfg_busy, 0);
      @(negedge clk);

      start_sample(2, 10, "ch2a");
      expect_result(2, 10, "ch2a", 0);
      start_sample(0, 7, "ch0x");
      expect_result(0, 7, "ch0x", 0);
      start_sample(1, 9, "ch1x");
      expect_result(1, 9, "ch1x", 0);
      start_sample(2, 10, "ch2b");
      expect_result(2, 30, "ch2b", 0);

      // Downstream stall: result must hold and no channel may be granted.
      bus.out_ready = 1'b0;
      start_sample(3, -7, "stall");
      lat = 0;
      while (!bus.valid_out && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("stall lat", lat, 3);
      check("stall data", bus.data_out, -7);
      bus.ch_valid = 4'hF;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check($sformatf("stall%0d valid", i), bus.valid_out, 1);
         check($sformatf("stall%0d data", i), bus.data_out, -7);
         check($sformatf("stall%0d id", i), bus.ch_id_out, 3);
         check($sformatf("stall%0d ready", i), bus.ch_ready, 0);
      end
      bus.ch_valid = '0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("release valid", bus.valid_out, 0);
      check("release idle", cfg_busy, 0);
      $display("result stall released");

      // Write while busy is dropped.
      start_sample(1, 5, "busywr");
      @(negedge clk);
      check("busywr busy", cfg_busy, 1);
      cfg_we = 1'b1; cfg_addr = 2'd1; cfg_data = -8'sd3;
      @(negedge clk);
      cfg_we = 1'b0;
      expect_result(1, 23, "busywr", 2);

      // Write in IDLE takes effect.
      cfg_we = 1'b1; cfg_addr = 2'd1; cfg_data = -8'sd3;
      @(negedge clk);
      cfg_we = 1'b0;
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      start_sample(1, 5, "c1a");
      expect_result(1, 5, "c1a", 0);
      start_sample(1, 5, "c1b");
      expect_result(1, -10, "c1b", 0);

      // Write on the same edge as a transfer applies to that sample.
      cfg_we = 1'b1; cfg_addr = 2'd1; cfg_data = 8'sd2;
      start_sample(1, 0, "samewr");
      cfg_we = 1'b0;
      expect_result(1, 15, "samewr", 0);

      // Flush during TAP1 discards the sample and its history update.
      start_sample(0, 100, "fl");
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("fl valid", bus.valid_out, 0);
      check("fl idle", cfg_busy, 0);
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (bus.valid_out) seen = 1'b1;
      end
      check("fl no_result", seen, 0);
      start_sample(0, 1, "flpost");
      expect_result(0, 1, "flpost", 0);

      // Reset during TAP2: outputs return to reset values, nothing partial emerges.
      start_sample(0, 100, "rs");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rs valid", bus.valid_out, 0);
      check("rs data", bus.data_out, 0);
      check("rs busy", cfg_busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (bus.valid_out) seen = 1'b1;
      end
      check("rs no_result", seen, 0);
      start_sample(0, 1, "rspost");
      expect_result(0, 1, "rspost", 0);
      start_sample(0, 3, "rspost2");
      expect_result(0, 5, "rspost2", 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
